// File: rtl/cuptor_multizone_ctrl.sv
// ---------------------------------------------------------------------------
// cuptor_multizone_ctrl
//
// Multi-zone electric-oven controller with an APB register slave. Each of
// NUM_ZONES heating zones has its own setpoint, cook time, remaining-time
// counter and IDLE/PREHEAT/COOK/PAUSE/DONE state machine. A shared
// prescaler produces the time-unit tick for all zones.
//
// Register map (zone z at base 4*z):
//   +0 CTRL        W: bit0 start, bit1 abort (strobes)   R: state code
//   +1 TIME_SET    RW
//   +2 TEMP_SET    RW
//   +3 TIME_REMAIN RO
//   0x20 DONE (R, W1C)   0x21 IRQ_MASK (RW)   0x22 STATUS (RO, bit0 = door)
//   Anything else reads 0 and ignores writes.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   paddr/psel/penable/pwrite/pwdata/prdata/pready   APB slave (0 wait states)
//   door              1 = door closed
//   temp_meas         measured temperature, zone z at [z*TEMP_W +: TEMP_W]
//   heater_en         heater drive per zone
//   timeout           per-zone done flags (mirror of DONE)
//   mod_ready         high while any done flag is set
//   irq               |(done & irq_mask)
//
// TIME_W and TEMP_W must not exceed the 8-bit APB data width.
// ---------------------------------------------------------------------------
module cuptor_multizone_ctrl #(
  parameter int NUM_ZONES = 2,
  parameter int TIME_W    = 8,
  parameter int TEMP_W    = 8,
  parameter int TICK_DIV  = 50
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  paddr,
  input  logic                        psel,
  input  logic                        penable,
  input  logic                        pwrite,
  input  logic [7:0]                  pwdata,
  output logic [7:0]                  prdata,
  output logic                        pready,
  input  logic                        door,
  input  logic [NUM_ZONES*TEMP_W-1:0] temp_meas,
  output logic [NUM_ZONES-1:0]        heater_en,
  output logic [NUM_ZONES-1:0]        timeout,
  output logic                        mod_ready,
  output logic                        irq
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREHEAT = 3'd1,
    ST_COOK    = 3'd2,
    ST_PAUSE   = 3'd3,
    ST_DONE    = 3'd4
  } zone_state_t;

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // -------------------------------------------------------------------------
  // Shared prescaler: one-cycle tick on the cycle the counter wraps.
  // -------------------------------------------------------------------------
  logic [PRESC_W-1:0] presc_reg;
  logic [PRESC_W-1:0] presc_next;
  logic               tick;

  always_comb begin
    tick       = (presc_reg == PRESC_W'(TICK_DIV - 1));
    presc_next = tick ? '0 : presc_reg + PRESC_W'(1);
  end

  // -------------------------------------------------------------------------
  // APB decode
  // -------------------------------------------------------------------------
  logic                 wr_en;
  logic                 rd_setup;
  logic                 zone_space;
  logic [NUM_ZONES-1:0] w1c_mask;
  logic [NUM_ZONES-1:0] done_set;
  logic [NUM_ZONES-1:0] done_reg;
  logic [NUM_ZONES-1:0] done_next;
  logic [NUM_ZONES-1:0] irq_mask_reg;
  logic [7:0]           rdata;

  // Per-zone register views, flattened so the read mux can see them.
  logic [NUM_ZONES*3-1:0]      state_flat;
  logic [NUM_ZONES*TIME_W-1:0] time_set_flat;
  logic [NUM_ZONES*TIME_W-1:0] remain_flat;
  logic [NUM_ZONES*TEMP_W-1:0] temp_set_flat;

  assign wr_en      = psel & penable & pwrite;
  assign rd_setup   = psel & ~penable & ~pwrite;
  assign zone_space = (paddr[7:5] == 3'b000);
  assign w1c_mask   = (wr_en && paddr == 8'h20) ? pwdata[NUM_ZONES-1:0] : '0;

  // A completion in the same cycle as a W1C of that bit keeps the bit set.
  assign done_next  = (done_reg & ~w1c_mask) | done_set;

  // -------------------------------------------------------------------------
  // Zones
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_ZONES; gi++) begin : g_zone
      zone_state_t       state_reg;
      zone_state_t       state_next;
      logic [TIME_W-1:0] remain_reg;
      logic [TIME_W-1:0] remain_next;
      logic [TIME_W-1:0] time_set_reg;
      logic [TEMP_W-1:0] temp_set_reg;
      logic              zone_wr;
      logic              start;
      logic              abort;
      logic              done_set_z;
      logic              temp_ok;
      logic [TEMP_W-1:0] temp_z;

      assign temp_z  = temp_meas[gi*TEMP_W +: TEMP_W];
      assign temp_ok = (temp_z >= temp_set_reg);
      assign zone_wr = wr_en && zone_space && (paddr[4:2] == 3'(gi));
      assign start   = zone_wr && (paddr[1:0] == 2'd0) && pwdata[0];
      assign abort   = zone_wr && (paddr[1:0] == 2'd0) && pwdata[1];

      // Priority: abort > door-open pause > tick decrement > start.
      always_comb begin
        state_next  = state_reg;
        remain_next = remain_reg;
        done_set_z  = 1'b0;
        if (abort) begin
          state_next  = ST_IDLE;
          remain_next = '0;
        end else begin
          case (state_reg)
            ST_IDLE: begin
              if (start && door && (time_set_reg != '0)) begin
                state_next  = ST_PREHEAT;
                remain_next = time_set_reg;
              end
            end
            ST_PREHEAT: begin
              if (!door) begin
                state_next = ST_PAUSE;
              end else if (temp_ok) begin
                state_next = ST_COOK;
              end
            end
            ST_COOK: begin
              if (!door) begin
                state_next = ST_PAUSE;
              end else if (tick) begin
                // <= 1 rather than == 1 so a zero count can never wrap.
                if (remain_reg <= TIME_W'(1)) begin
                  remain_next = '0;
                  state_next  = ST_DONE;
                  done_set_z  = 1'b1;
                end else begin
                  remain_next = remain_reg - TIME_W'(1);
                end
              end
            end
            ST_PAUSE: begin
              if (door) begin
                state_next = ST_PREHEAT;
              end
            end
            ST_DONE: begin
              if (w1c_mask[gi]) begin
                state_next = ST_IDLE;
              end
            end
            default: begin
              state_next = ST_IDLE;
            end
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          state_reg    <= ST_IDLE;
          remain_reg   <= '0;
          time_set_reg <= '0;
          temp_set_reg <= '0;
        end else begin
          state_reg  <= state_next;
          remain_reg <= remain_next;
          if (zone_wr && paddr[1:0] == 2'd1) begin
            time_set_reg <= pwdata[TIME_W-1:0];
          end
          if (zone_wr && paddr[1:0] == 2'd2) begin
            temp_set_reg <= pwdata[TEMP_W-1:0];
          end
        end
      end

      assign done_set[gi]                       = done_set_z;
      assign state_flat[gi*3 +: 3]              = state_reg;
      assign time_set_flat[gi*TIME_W +: TIME_W] = time_set_reg;
      assign remain_flat[gi*TIME_W +: TIME_W]   = remain_reg;
      assign temp_set_flat[gi*TEMP_W +: TEMP_W] = temp_set_reg;

      // Setpoint changes take effect on the heater immediately.
      assign heater_en[gi] = (state_reg == ST_PREHEAT) ||
                             ((state_reg == ST_COOK) && !temp_ok);
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Read mux (captured into prdata during the setup phase)
  // -------------------------------------------------------------------------
  always_comb begin
    rdata = 8'h00;
    for (int z = 0; z < NUM_ZONES; z++) begin
      if (zone_space && paddr[4:2] == 3'(z)) begin
        case (paddr[1:0])
          2'd0:    rdata = 8'(state_flat[z*3 +: 3]);
          2'd1:    rdata = 8'(time_set_flat[z*TIME_W +: TIME_W]);
          2'd2:    rdata = 8'(temp_set_flat[z*TEMP_W +: TEMP_W]);
          default: rdata = 8'(remain_flat[z*TIME_W +: TIME_W]);
        endcase
      end
    end
    case (paddr)
      8'h20:   rdata = 8'(done_reg);
      8'h21:   rdata = 8'(irq_mask_reg);
      8'h22:   rdata = {7'b0, door};
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Shared registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_reg    <= '0;
      done_reg     <= '0;
      irq_mask_reg <= '0;
      prdata       <= 8'h00;
    end else begin
      presc_reg <= presc_next;
      done_reg  <= done_next;
      if (wr_en && paddr == 8'h21) begin
        irq_mask_reg <= pwdata[NUM_ZONES-1:0];
      end
      if (rd_setup) begin
        prdata <= rdata;
      end
    end
  end

  assign pready    = 1'b1;
  assign timeout   = done_reg;
  assign mod_ready = |done_reg;
  assign irq       = |(done_reg & irq_mask_reg);

endmodule

// File: tb/tb_cuptor_multizone_ctrl.sv
// ---------------------------------------------------------------------------
// Directed testbench for cuptor_multizone_ctrl (2 zones, TICK_DIV = 4).
// Inputs change 1 time unit after a rising edge and outputs are sampled
// there too. The bench keeps its own copy of the free-running prescaler so
// it knows which edges carry a tick.
// ---------------------------------------------------------------------------
module tb_cuptor_multizone_ctrl;

  localparam int NZ = 2;
  localparam int TW = 8;
  localparam int PW = 8;
  localparam int TD = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       paddr;
  logic             psel;
  logic             penable;
  logic             pwrite;
  logic [7:0]       pwdata;
  logic [7:0]       prdata;
  logic             pready;
  logic             door;
  logic [NZ*PW-1:0] temp_meas;
  logic [NZ-1:0]    heater_en;
  logic [NZ-1:0]    timeout;
  logic             mod_ready;
  logic             irq;

  int checks = 0;
  int errors = 0;

  cuptor_multizone_ctrl #(
    .NUM_ZONES(NZ),
    .TIME_W   (TW),
    .TEMP_W   (PW),
    .TICK_DIV (TD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .paddr    (paddr),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready),
    .door     (door),
    .temp_meas(temp_meas),
    .heater_en(heater_en),
    .timeout  (timeout),
    .mod_ready(mod_ready),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  // Bench copy of the prescaler: value 0 right after an edge means that
  // edge carried a tick (outside reset).
  logic [1:0] presc_m;
  always @(posedge clk) begin
    if (reset) presc_m <= 2'd0;
    else       presc_m <= presc_m + 2'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      step(1);
      n++;
    end while (presc_m != 2'd0 && n < 8);
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [7:0] d);
    paddr   = a;
    pwdata  = d;
    pwrite  = 1'b1;
    psel    = 1'b1;
    penable = 1'b0;
    step(1);
    penable = 1'b1;
    step(1);
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    $display("apb write addr=0x%02h data=0x%02h", a, d);
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [7:0] d);
    paddr   = a;
    pwrite  = 1'b0;
    psel    = 1'b1;
    penable = 1'b0;
    step(1);
    penable = 1'b1;
    d       = prdata;
    step(1);
    psel    = 1'b0;
    penable = 1'b0;
    $display("apb read  addr=0x%02h data=0x%02h", a, d);
  endtask

  task automatic read_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] d;
    apb_read(a, d);
    check(tag, {24'b0, d}, {24'b0, exp});
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    reset     = 1'b1;
    paddr     = 8'h00;
    psel      = 1'b0;
    penable   = 1'b0;
    pwrite    = 1'b0;
    pwdata    = 8'h00;
    door      = 1'b1;
    temp_meas = '0;
    step(3);

    // Reset state
    check("rst_heater", {30'b0, heater_en}, 32'h0);
    check("rst_timeout", {30'b0, timeout}, 32'h0);
    check("rst_mod_ready", {31'b0, mod_ready}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_prdata", {24'b0, prdata}, 32'h0);
    check("rst_pready", {31'b0, pready}, 32'h1);
    reset = 1'b0;
    step(1);
    read_check("rst_ctrl0", 8'h00, 8'h00);

    // Normal cook on zone 0: preheat below setpoint, then count 3,2,1,0
    apb_write(8'h02, 8'd100);
    apb_write(8'h01, 8'd3);
    temp_meas[7:0] = 8'd80;
    apb_write(8'h00, 8'h01);
    check("cook_preheat_heater", {31'b0, heater_en[0]}, 32'h1);
    read_check("cook_ctrl_preheat", 8'h00, 8'd1);
    read_check("cook_remain3", 8'h03, 8'd3);
    temp_meas[7:0] = 8'd120;
    step(1);
    check("cook_heater_off", {31'b0, heater_en[0]}, 32'h0);
    wait_tick();
    read_check("cook_remain2", 8'h03, 8'd2);
    wait_tick();
    read_check("cook_remain1", 8'h03, 8'd1);
    wait_tick();
    read_check("cook_remain0", 8'h03, 8'd0);
    check("cook_timeout", {30'b0, timeout}, 32'h1);
    check("cook_mod_ready", {31'b0, mod_ready}, 32'h1);
    check("cook_done_heater", {31'b0, heater_en[0]}, 32'h0);
    check("cook_irq_masked", {31'b0, irq}, 32'h0);
    read_check("cook_ctrl_done", 8'h00, 8'd4);
    read_check("cook_done_reg", 8'h20, 8'h01);
    apb_write(8'h20, 8'h01);
    check("w1c_mod_ready", {31'b0, mod_ready}, 32'h0);
    check("w1c_timeout", {30'b0, timeout}, 32'h0);
    read_check("w1c_ctrl_idle", 8'h00, 8'd0);

    // Door pause with resume
    apb_write(8'h00, 8'h01);
    step(1);
    wait_tick();
    door = 1'b0;
    step(20);
    check("pause_heater", {31'b0, heater_en[0]}, 32'h0);
    read_check("pause_ctrl", 8'h00, 8'd3);
    read_check("pause_remain", 8'h03, 8'd2);
    door = 1'b1;
    step(1);
    check("resume_preheat_heater", {31'b0, heater_en[0]}, 32'h1);
    step(1);
    check("resume_cook_heater", {31'b0, heater_en[0]}, 32'h0);
    wait_tick();
    check("resume_not_done", {30'b0, timeout}, 32'h0);
    wait_tick();
    check("resume_done", {30'b0, timeout}, 32'h1);
    apb_write(8'h20, 8'h01);

    // Temperature threshold behaviour and abort mid-cook
    apb_write(8'h01, 8'd200);
    temp_meas[7:0] = 8'd80;
    apb_write(8'h00, 8'h01);
    step(5);
    check("cold_heater_on", {31'b0, heater_en[0]}, 32'h1);
    read_check("cold_stays_preheat", 8'h00, 8'd1);
    temp_meas[7:0] = 8'd100;
    step(1);
    check("at_setpoint_heater", {31'b0, heater_en[0]}, 32'h0);
    read_check("at_setpoint_cook", 8'h00, 8'd2);
    temp_meas[7:0] = 8'd99;
    step(1);
    check("cook_99_heater", {31'b0, heater_en[0]}, 32'h1);
    temp_meas[7:0] = 8'd101;
    step(1);
    check("cook_101_heater", {31'b0, heater_en[0]}, 32'h0);
    apb_write(8'h00, 8'h02);
    read_check("abort_ctrl", 8'h00, 8'd0);
    read_check("abort_remain", 8'h03, 8'd0);
    check("abort_heater", {31'b0, heater_en[0]}, 32'h0);

    // Ignored starts
    apb_write(8'h01, 8'd0);
    apb_write(8'h00, 8'h01);
    read_check("start_time0_ctrl", 8'h00, 8'd0);
    check("start_time0_heater", {31'b0, heater_en[0]}, 32'h0);
    apb_write(8'h01, 8'd5);
    door = 1'b0;
    apb_write(8'h00, 8'h01);
    read_check("start_door_open_ctrl", 8'h00, 8'd0);
    check("start_door_open_heater", {31'b0, heater_en[0]}, 32'h0);
    read_check("status_door_open", 8'h22, 8'h00);
    door = 1'b1;
    read_check("status_door_closed", 8'h22, 8'h01);
    apb_write(8'h00, 8'h03);
    read_check("abort_and_start_ctrl", 8'h00, 8'd0);

    // Two zones completing on the same tick, IRQ mask and W1C
    apb_write(8'h01, 8'd1);
    apb_write(8'h05, 8'd1);
    apb_write(8'h06, 8'd100);
    temp_meas = {8'd80, 8'd80};
    apb_write(8'h00, 8'h01);
    apb_write(8'h04, 8'h01);
    read_check("dual_ctrl0", 8'h00, 8'd1);
    read_check("dual_ctrl1", 8'h04, 8'd1);
    check("dual_heaters", {30'b0, heater_en}, 32'h3);
    temp_meas = {8'd120, 8'd120};
    step(1);
    n = 0;
    while (timeout == 2'b00 && n < 8) begin
      step(1);
      n++;
    end
    check("dual_done_same_cycle", {30'b0, timeout}, 32'h3);
    read_check("dual_done_reg", 8'h20, 8'h03);
    check("dual_irq_unmasked0", {31'b0, irq}, 32'h0);
    apb_write(8'h21, 8'h02);
    check("dual_irq_on", {31'b0, irq}, 32'h1);
    apb_write(8'h20, 8'h02);
    check("dual_irq_off", {31'b0, irq}, 32'h0);
    read_check("dual_done_after_w1c", 8'h20, 8'h01);
    read_check("dual_ctrl1_idle", 8'h04, 8'd0);
    read_check("dual_ctrl0_done", 8'h00, 8'd4);

    // Unmapped and unimplemented addresses
    read_check("unmapped_30", 8'h30, 8'h00);
    apb_write(8'h30, 8'hFF);
    read_check("unmapped_wr_done", 8'h20, 8'h01);
    read_check("unmapped_wr_mask", 8'h21, 8'h02);
    read_check("zone2_ctrl", 8'h08, 8'h00);
    apb_write(8'h09, 8'h55);
    read_check("zone2_time_set", 8'h09, 8'h00);
    read_check("unmapped_23", 8'h23, 8'h00);

    // Reset during a cook
    apb_write(8'h21, 8'h03);
    check("pre_reset_irq", {31'b0, irq}, 32'h1);
    apb_write(8'h05, 8'd200);
    temp_meas[15:8] = 8'd100;
    apb_write(8'h04, 8'h01);
    step(1);
    temp_meas[15:8] = 8'd99;
    step(1);
    check("pre_reset_heater1", {31'b0, heater_en[1]}, 32'h1);
    read_check("pre_reset_ctrl1", 8'h04, 8'd2);
    reset = 1'b1;
    step(1);
    check("mid_reset_heater", {30'b0, heater_en}, 32'h0);
    check("mid_reset_timeout", {30'b0, timeout}, 32'h0);
    check("mid_reset_mod_ready", {31'b0, mod_ready}, 32'h0);
    check("mid_reset_irq", {31'b0, irq}, 32'h0);
    check("mid_reset_prdata", {24'b0, prdata}, 32'h0);
    reset = 1'b0;
    step(1);
    read_check("post_reset_mask", 8'h21, 8'h00);
    read_check("post_reset_time_set1", 8'h05, 8'h00);
    read_check("post_reset_ctrl1", 8'h04, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
